// File: rtl/vaddsub_rr_sched.sv
// vaddsub_rr_sched: round-robin front end sharing one FP16 add/sub pipeline.
// Subtracts issue as adds with B's sign flipped; a tag pipe routes results home.
module vaddsub_rr_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [16*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]    req_sub,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [15:0]         resp_data,
    output logic                resp_ovf,
    output logic                add_enable,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    input  logic [15:0]         add_out,
    input  logic                add_overflow,
    input  logic                add_out_valid,
    output logic                busy,
    output logic                err_orphan
);
    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] nxt_ptr;
    logic [TAG_W-1:0] iss_tag;
    logic             any;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic             sel_sub;
    logic [LAT-1:0]   stg_v;
    logic [TAG_W-1:0] stg_t [LAT];
    logic             last_v;
    logic [TAG_W-1:0] last_t;

    // Two passes: indices at/after ptr first, then wrap to the low indices.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && i >= int'(ptr) && req_valid[i]) begin
                any   = 1'b1;
                grant = TAG_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req_valid[i]) begin
                any   = 1'b1;
                grant = TAG_W'(i);
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == TAG_W'(i)) begin
                sel_a   = req_a[16*i +: 16];
                sel_b   = req_b[16*i +: 16];
                sel_sub = req_sub[i];
            end
            req_ready[i] = any && (grant == TAG_W'(i));
        end
    end

    assign nxt_ptr = (grant == TAG_W'(N_REQ-1)) ? '0 : grant + 1'b1;
    assign last_v  = stg_v[LAT-1];
    assign last_t  = stg_t[LAT-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = last_v && add_out_valid && (last_t == TAG_W'(i));
        end
    end

    assign resp_data = add_out;
    assign resp_ovf  = add_overflow;
    assign busy      = add_enable | (|stg_v);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr        <= '0;
            add_enable <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            iss_tag    <= '0;
            stg_v      <= '0;
            err_orphan <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                stg_t[k] <= '0;
            end
        end else begin
            add_enable <= any;
            iss_tag    <= grant;
            if (any) begin
                ptr   <= nxt_ptr;
                add_a <= sel_a;
                add_b <= sel_b ^ {sel_sub, 15'b0};
            end
            stg_v[0] <= add_enable;
            stg_t[0] <= iss_tag;
            for (int k = 1; k < LAT; k++) begin
                stg_v[k] <= stg_v[k-1];
                stg_t[k] <= stg_t[k-1];
            end
            if (last_v != add_out_valid) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vaddsub_rr_sched.sv
// Bench for vaddsub_rr_sched: behavioural FP16 adder stub plus an
// operation-queue scoreboard predicting grants, issue and responses.
module tb_vaddsub_rr_sched;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           nRST = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_sub = '0;
    logic [16*N-1:0] req_a = '0;
    logic [16*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [15:0]    resp_data;
    logic           resp_ovf;
    logic           add_enable;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic [15:0]    add_out;
    logic           add_overflow;
    logic           add_out_valid;
    logic           busy;
    logic           err_orphan;
    logic           force_ov = 1'b0;

    logic           p1_v, p2_v, p1_o, p2_o;
    logic [15:0]    p1_d, p2_d;

    typedef struct {
        int          tag;
        logic [15:0] a;
        logic [15:0] b;
        int          due;
    } op_t;

    op_t  q[$];
    int   cyc = 0;
    int   mptr = 0;
    bit   merr = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_resp = 0;
    int   n0;

    logic [N-1:0] s_ready, s_resp_valid;
    logic [15:0]  s_resp_data, s_add_a, s_add_b;
    logic         s_resp_ovf, s_add_en, s_busy, s_err;

    logic [15:0] tbl [8] = '{16'h3800, 16'h3C00, 16'h3E00, 16'h4000,
                             16'h4200, 16'h4400, 16'h4500, 16'h7BFF};

    always #5 CLK = ~CLK;

    vaddsub_rr_sched #(.N_REQ(N), .LAT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ovf(resp_ovf),
        .add_enable(add_enable), .add_a(add_a), .add_b(add_b),
        .add_out(add_out), .add_overflow(add_overflow),
        .add_out_valid(add_out_valid),
        .busy(busy), .err_orphan(err_orphan)
    );

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) e = 1;
        else m = m + 1.0;
        for (int i = 15; i < e; i++) m = m * 2.0;
        for (int i = e; i < 15; i++) m = m / 2.0;
        return h[15] ? -m : m;
    endfunction

    // {overflow, fp16 sum}; round to nearest, overflow saturates to Inf.
    function automatic logic [16:0] fpadd(input logic [15:0] a, input logic [15:0] b);
        real  r, m;
        int   e, bits;
        logic s;
        r = h2r(a) + h2r(b);
        s = (r < 0.0);
        m = s ? -r : r;
        if (m == 0.0) return 17'h0;
        e = 15;
        while (m >= 2.0 && e < 31) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        if (m >= 1.0) bits = e * 1024 + $rtoi((m - 1.0) * 1024.0 + 0.5);
        else bits = $rtoi(m * 1024.0 + 0.5);
        if (bits >= 'h7C00) return {1'b1, s, 15'h7C00};
        return {1'b0, s, bits[14:0]};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            p1_v <= 1'b0; p1_o <= 1'b0; p1_d <= '0;
            p2_v <= 1'b0; p2_o <= 1'b0; p2_d <= '0;
        end else begin
            p1_v <= add_enable;
            {p1_o, p1_d} <= fpadd(add_a, add_b);
            p2_v <= p1_v; p2_o <= p1_o; p2_d <= p1_d;
        end
    end

    assign add_out       = p2_d;
    assign add_overflow  = p2_o;
    assign add_out_valid = p2_v | force_ov;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        int          g, j;
        logic [N-1:0] er;
        logic [16:0] r;
        bit          due, en, be;
        logic [15:0] ea, eb;
        @(negedge CLK);
        s_ready = req_ready; s_resp_valid = resp_valid;
        s_resp_data = resp_data; s_resp_ovf = resp_ovf;
        s_add_en = add_enable; s_add_a = add_a; s_add_b = add_b;
        s_busy = busy; s_err = err_orphan;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        en = 0; be = 0; ea = '0; eb = '0;
        foreach (q[i]) begin
            if (q[i].due - 2 <= cyc && cyc <= q[i].due) be = 1;
            if (q[i].due == cyc + 2) begin en = 1; ea = q[i].a; eb = q[i].b; end
        end
        chk("add_enable", 32'(add_enable), 32'(en));
        if (en) begin
            chk("add_a", 32'(add_a), 32'(ea));
            chk("add_b", 32'(add_b), 32'(eb));
        end
        chk("busy", 32'(busy), 32'(be));
        chk("err_orphan", 32'(err_orphan), 32'(merr));
        er = '0; due = 0; r = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            due = 1;
            er[q[0].tag] = 1'b1;
            r = fpadd(q[0].a, q[0].b);
        end
        chk("resp_valid", 32'(resp_valid), 32'(er));
        if (due) begin
            chk("resp_data", 32'(resp_data), 32'(r[15:0]));
            chk("resp_ovf", 32'(resp_ovf), 32'(r[16]));
            void'(q.pop_front());
        end
        if (|resp_valid) n_resp++;
        if (force_ov && !due) merr = 1;
        if (g >= 0) begin
            q.push_back('{tag: g, a: req_a[16*g +: 16],
                          b: req_b[16*g +: 16] ^ {req_sub[g], 15'b0},
                          due: cyc + 3});
            mptr = (g + 1) % N;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i] = s;
        req_valid[i] = 1'b1;
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        req_valid = '0;
        q.delete();
        mptr = 0;
        merr = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_enable", 32'(add_enable), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_err", 32'(err_orphan), 0);
        nRST = 1'b1;

        issue(0, 16'h3C00, 16'h4000, 1'b0);
        tick();
        chk("add_en_t1", 32'(s_add_en), 1);
        tick();
        tick();
        chk("add_resp_valid", 32'(s_resp_valid), 32'h1);
        chk("add_resp_data", 32'(s_resp_data), 32'h4200);
        chk("add_resp_ovf", 32'(s_resp_ovf), 0);
        tick();
        chk("add_busy_t4", 32'(s_busy), 0);

        issue(2, 16'h4200, 16'h3C00, 1'b1);
        tick();
        chk("sub_add_b", 32'(s_add_b), 32'hBC00);
        tick();
        tick();
        chk("sub_resp_valid", 32'(s_resp_valid), 32'h4);
        chk("sub_resp_data", 32'(s_resp_data), 32'h4000);
        tick();

        issue(1, 16'h7BFF, 16'h7BFF, 1'b0);
        tick();
        tick();
        tick();
        chk("ovf_resp_valid", 32'(s_resp_valid), 32'h2);
        chk("ovf_resp_data", 32'(s_resp_data), 32'h7C00);
        chk("ovf_resp_ovf", 32'(s_resp_ovf), 1);
        tick();

        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = tbl[i + 1];
            req_b[16*i +: 16] = 16'h3C00;
        end
        req_sub = '0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_grant", 32'(s_ready), 32'(1 << (k % 4)));
        end
        req_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_solo_grant", 32'(s_ready), 32'h8);
        end
        req_valid = '0;
        repeat (5) tick();

        repeat (300) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[16*i +: 16] = tbl[$urandom_range(7)];
                req_b[16*i +: 16] = tbl[$urandom_range(7)];
                req_sub[i] = 1'($urandom);
            end
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("orphan_held", 32'(s_err), 1);
            chk("orphan_no_resp", 32'(s_resp_valid), 0);
        end
        do_reset();
        tick();
        chk("orphan_cleared", 32'(s_err), 0);

        issue(0, 16'h3C00, 16'h3C00, 1'b0);
        issue(1, 16'h4000, 16'h3C00, 1'b0);
        issue(2, 16'h4200, 16'h3C00, 1'b1);
        do_reset();
        n0 = n_resp;
        repeat (6) tick();
        chk("midrst_no_resp", 32'(n_resp), 32'(n0));
        chk("midrst_err", 32'(s_err), 0);
        req_valid = 4'b0011;
        tick();
        chk("midrst_grant0", 32'(s_ready), 32'h1);
        req_valid = '0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vaddsub_rr_sched.md
# vaddsub_rr_sched

Round-robin scheduler that shares one 2-cycle FP16 add/sub pipeline among `N_REQ` requesters.
- Accepts at most one operation per cycle through per-requester valid/ready handshakes.
- Converts subtract requests to adds by flipping the sign of operand B.
- Drives the adder's `enable`/`port_a`/`port_b` from a registered issue stage.
- Routes each result back to its originating requester using an internal tag pipeline that mirrors the adder latency.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `LAT`, 2: adder latency in cycles, from `enable` sampled to `out_valid`.
- `TAG_W`, `$clog2(N_REQ)`: requester index width.

Ports:
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `req_valid`  in  `N_REQ`  requester i has an operation pending
- `req_ready`  out  `N_REQ`  one-hot grant; operation i is accepted when `req_valid[i] & req_ready[i]`
- `req_a`  in  `16*N_REQ`  FP16 operand A; slice i = `[16*i +: 16]`
- `req_b`  in  `16*N_REQ`  FP16 operand B, same slicing as `req_a`
- `req_sub`  in  `N_REQ`  1 = compute A−B, 0 = A+B
- `resp_valid`  out  `N_REQ`  one-hot; result for requester i valid this cycle
- `resp_data`  out  16  FP16 result, shared by all requesters
- `resp_ovf`  out  1  overflow flag accompanying `resp_data`
- `add_enable`  out  1  to adder `enable`
- `add_a`  out  16  to adder `port_a`
- `add_b`  out  16  to adder `port_b`
- `add_out`  in  16  from adder `out`
- `add_overflow`  in  1  from adder `overflow`
- `add_out_valid`  in  1  from adder `out_valid`
- `busy`  out  1  any operation issued or in flight
- `err_orphan`  out  1  sticky tag/valid mismatch error

## Operation
- **Arbitration.** Rotating pointer `ptr` (`TAG_W` bits, reset 0). `grant` is the first i with `req_valid[i]`, searching `ptr`, `ptr+1`, … modulo `N_REQ`.
  - `req_ready = onehot(grant)` when any `req_valid` is set, else 0. `req_ready` is combinational from `req_valid`.
  - On accept, `ptr <= grant+1`, wrapping `N_REQ-1 -> 0`. With no accept, `ptr` holds.
- **Issue register.** Updated every cycle.
  - `add_enable <= accept`.
  - `add_a <= req_a[grant]`.
  - `add_b <= req_b[grant] ^ {req_sub[grant], 15'b0}`.
  - `iss_tag <= grant`.
  - When there is no accept, `add_a`/`add_b` hold their previous values.
  - The sign flip applies unconditionally, including to NaN and Inf operands; the adder resolves specials.
- **Tag pipeline.** `LAT` stages of {valid, tag}.
  - Stage 0 loads {`add_enable`, `iss_tag`}.
  - Stage k loads stage k−1.
  - The last stage aligns with `add_out_valid`.
- **Response.** Combinational.
  - `resp_valid = onehot(last.tag)` when `last.valid & add_out_valid`, else 0.
  - `resp_data = add_out`, `resp_ovf = add_overflow`, always driven.
  - Responses have no backpressure: requesters must consume `resp_valid` in the cycle it is asserted.
- **Orphan error.** `err_orphan` sets on any cycle where `last.valid != add_out_valid`. It stays set until reset. A mismatch cycle produces no `resp_valid`.
- **Busy.** `busy = add_enable | OR(stage.valid)`.

## Timing
- Accept at cycle T. `add_enable=1` during T+1. `add_out_valid` and `resp_valid[i]` during T+1+LAT, which is T+3 for the default `LAT`.
- Throughput is one operation per cycle. Results return in issue order.
- Fairness:
  - With all requesters continuously valid, grants follow 0,1,2,…,`N_REQ`-1,0, …
  - A single continuously valid requester is granted every cycle.
  - A requester waits at most `N_REQ`−1 accepts before its grant.
- Operand capture: a requester may change `req_a`/`req_b`/`req_sub` in the cycle after its accept without affecting the issued operation.
- Reset values (asynchronous `nRST` low):
  - `ptr`, `add_enable`, `add_a`, `add_b`, `iss_tag`, all tag stages, and `err_orphan` are 0.
  - Hence `req_ready`, `resp_valid`, `busy` are 0 unless `req_valid` is set; `resp_data` follows `add_out`.
- Reset mid-operation:
  - All in-flight operations are discarded and no response is produced for them.
  - The adder shares `nRST`, so no orphan error is raised after reset.
- Simultaneous events: an accept in the same cycle as a response is legal, including for the same requester.

## Test plan
- **Single add.** Req0 issues A=0x3C00, B=0x4000, sub=0, accepted at T. Required: `add_enable=1` at T+1; `resp_valid=0001`, `resp_data=0x4200`, `resp_ovf=0` at T+3; `busy` low at T+4.
- **Subtract.** Req2 issues A=0x4200, B=0x3C00, sub=1. Required: `add_b=0xBC00`; `resp_valid=0100`, `resp_data=0x4000`.
- **Overflow.** Req1 issues 0x7BFF+0x7BFF. Required: `resp_data=0x7C00`, `resp_ovf=1`, `resp_valid=0010`.
- **Round-robin.** All four requesters hold `req_valid=1` for 8 cycles with A=0x3C00·(i+1)-distinct operands. Required:
  - grants 0,1,2,3,0,1,2,3 on consecutive cycles;
  - responses in the same order, each 3 cycles after its grant, with correct tags;
  - then drop req0–req2 and check that req3 alone is granted every cycle.
- **Orphan.** Force `add_out_valid=1` for one cycle with the tag pipeline empty. Required: `err_orphan=1` from the next cycle, held over 10 further cycles; `resp_valid` stays 0; cleared only by `nRST`.
- **Reset mid-flight.** Accept 3 ops on consecutive cycles, then pulse `nRST` low one cycle after the third accept. Required:
  - zero `resp_valid` pulses after reset;
  - `ptr` restarts at 0, so the next simultaneous req0/req1 grants req0.
